flight_sequencer: RTL and testbench

//  Sequencing controller for the three-axis spacial position datapath. It drives the one-hot

---
 rtl/flight_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_flight_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flight_sequencer.sv
// Select sequencer for the X/Y/Z position datapath: homing, cruise, single-cycle warp, cooldown.
// Optional feature: define SAFE_DECEL_EN to pass mode-to-mode changes through a one-cycle HOLD at zero velocity.
module flight_sequencer #(
    parameter int HOME_CYCLES     = 2,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_mode,
    output logic [3:0] mode_sel,
    output logic [3:0] pos_sel,
    output logic       warp_active,
    output logic       busy,
    output logic [7:0] warp_count
);

    localparam logic [2:0] S_HOMING   = 3'd0;
    localparam logic [2:0] S_CRUISE   = 3'd1;
    localparam logic [2:0] S_WARP     = 3'd2;
    localparam logic [2:0] S_COOLDOWN = 3'd3;
`ifdef SAFE_DECEL_EN
    localparam logic [2:0] S_HOLD     = 3'd4;
`endif

    localparam logic [1:0] OP_SET_MODE = 2'b01;
    localparam logic [1:0] OP_WARP     = 2'b10;
    localparam logic [1:0] OP_HOME     = 2'b11;

    localparam logic [3:0] MODE_ZERO   = 4'b0001;
    localparam logic [3:0] POS_ORIGIN  = 4'b0001;
    localparam logic [3:0] POS_INTEG   = 4'b0010;
    localparam logic [3:0] POS_WARP    = 4'b0100;

    localparam logic [CNT_W-1:0] HOME_LAST = CNT_W'(HOME_CYCLES - 1);
    localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mode_q, mode_d;
    logic [3:0]       pos_q, pos_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             warp_q, warp_d;
    logic [7:0]       wcnt_q, wcnt_d;
`ifdef SAFE_DECEL_EN
    logic [3:0]       pend_q, pend_d;
    logic             hold_needed;
`endif
    logic             accept;

    function automatic logic [3:0] mode_onehot(input logic [1:0] m);
        return 4'b0001 << m;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign accept = cmd_valid && ready_q;

`ifdef SAFE_DECEL_EN
    // Only a switch between two different moving modes needs the zero-velocity hold.
    assign hold_needed = (mode_q != MODE_ZERO) && (cmd_mode != 2'd0) &&
                         (mode_onehot(cmd_mode) != mode_q);
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        mode_d  = mode_q;
        wcnt_d  = wcnt_q;
`ifdef SAFE_DECEL_EN
        pend_d  = pend_q;
`endif
        case (state_q)
            S_HOMING: begin
                if (cnt_q == HOME_LAST) state_d = S_CRUISE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            S_CRUISE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_SET_MODE: begin
`ifdef SAFE_DECEL_EN
                            if (hold_needed) begin
                                state_d = S_HOLD;
                                pend_d  = mode_onehot(cmd_mode);
                                mode_d  = MODE_ZERO;
                            end else begin
                                mode_d  = mode_onehot(cmd_mode);
                            end
`else
                            mode_d = mode_onehot(cmd_mode);
`endif
                        end
                        OP_WARP: begin
                            state_d = S_WARP;
                            wcnt_d  = sat_inc8(wcnt_q);
                        end
                        OP_HOME: begin
                            state_d = S_HOMING;
                            mode_d  = MODE_ZERO;
                        end
                        default: ;
                    endcase
                end
            end
            S_WARP: state_d = S_COOLDOWN;
            S_COOLDOWN: begin
                if (cnt_q == COOL_LAST) state_d = S_CRUISE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
`ifdef SAFE_DECEL_EN
            S_HOLD: begin
                state_d = S_CRUISE;
                mode_d  = pend_q;
            end
`endif
            default: begin
                state_d = S_HOMING;
                mode_d  = MODE_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they appear registered with the state itself.
    always_comb begin
        pos_d   = POS_INTEG;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        warp_d  = 1'b0;
        case (state_d)
            S_HOMING: pos_d = POS_ORIGIN;
            S_CRUISE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
            S_WARP: begin
                pos_d  = POS_WARP;
                warp_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HOMING;
            cnt_q   <= '0;
            mode_q  <= MODE_ZERO;
            pos_q   <= POS_ORIGIN;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            warp_q  <= 1'b0;
            wcnt_q  <= 8'd0;
`ifdef SAFE_DECEL_EN
            pend_q  <= MODE_ZERO;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            warp_q  <= warp_d;
            wcnt_q  <= wcnt_d;
`ifdef SAFE_DECEL_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign cmd_ready   = ready_q;
    assign mode_sel    = mode_q;
    assign pos_sel     = pos_q;
    assign warp_active = warp_q;
    assign busy        = busy_q;
    assign warp_count  = wcnt_q;

endmodule

// File: tb/tb_flight_sequencer.sv
// Scoreboard bench for flight_sequencer: a timeline model queues expected per-cycle outputs, a monitor compares.
// Follows SAFE_DECEL_EN the same way as the design build.
module tb_flight_sequencer;

    localparam int HOME_CYCLES     = 2;
    localparam int COOLDOWN_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [1:0] cmd_mode;
    logic [3:0] mode_sel;
    logic [3:0] pos_sel;
    logic       warp_active;
    logic       busy;
    logic [7:0] warp_count;

    flight_sequencer #(
        .HOME_CYCLES(HOME_CYCLES),
        .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
        .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .mode_sel(mode_sel), .pos_sel(pos_sel),
        .warp_active(warp_active), .busy(busy), .warp_count(warp_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] mode;
        logic [3:0] pos;
        logic       ready;
        logic       wa;
        logic       busy;
        logic [7:0] wc;
    } obs_t;

    obs_t exp_q[$];
    obs_t plan[$];
    obs_t cur;
    obs_t mon_e, mon_g;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 0;
    int   m_mode, m_wc, warps_acc, cyc;

    function automatic logic [3:0] oh(input int m);
        case (m)
            0: return 4'b0001;
            1: return 4'b0010;
            2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic obs_t mk(input logic [3:0] mode, input logic [3:0] pos,
                                input logic ready, input logic wa, input logic bsy,
                                input logic [7:0] wc);
        obs_t o;
        o.mode = mode; o.pos = pos; o.ready = ready; o.wa = wa; o.busy = bsy; o.wc = wc;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        return mk(mode_sel, pos_sel, cmd_ready, warp_active, busy, warp_count);
    endfunction

    // Model: plan holds the non-cruise cycles still ahead; an empty plan means cruising and ready.
    task automatic model_reset();
        plan.delete();
        m_mode = 0;
        m_wc   = 0;
        for (int i = 0; i < HOME_CYCLES; i++) plan.push_back(mk(4'b0001, 4'b0001, 0, 0, 1, 8'd0));
        cur = plan[0];
    endtask

    task automatic model_accept();
        case (cmd_op)
            2'b01: begin
`ifdef SAFE_DECEL_EN
                if (m_mode != 0 && cmd_mode != 0 && int'(cmd_mode) != m_mode)
                    plan.push_back(mk(4'b0001, 4'b0010, 0, 0, 1, m_wc[7:0]));
`endif
                m_mode = int'(cmd_mode);
            end
            2'b10: begin
                warps_acc++;
                if (m_wc < 255) m_wc++;
                plan.push_back(mk(oh(m_mode), 4'b0100, 0, 1, 1, m_wc[7:0]));
                for (int i = 0; i < COOLDOWN_CYCLES; i++)
                    plan.push_back(mk(oh(m_mode), 4'b0010, 0, 0, 1, m_wc[7:0]));
            end
            2'b11: begin
                m_mode = 0;
                for (int i = 0; i < HOME_CYCLES; i++)
                    plan.push_back(mk(4'b0001, 4'b0001, 0, 0, 1, m_wc[7:0]));
            end
            default: ;
        endcase
    endtask

    task automatic tick(input bit f_en, input bit f_valid, input logic [1:0] f_op,
                        input logic [1:0] f_mode);
        bit acc;
        @(posedge clk);
        #1;
        cyc++;
        acc = 0;
        if (plan.size() > 0) void'(plan.pop_front());
        else if (cmd_valid) begin
            acc = 1;
            model_accept();
        end
        cur = (plan.size() > 0) ? plan[0] : mk(oh(m_mode), 4'b0010, 1, 0, 0, m_wc[7:0]);
        exp_q.push_back(cur);
        if (!(cmd_valid && !acc)) begin
            if (f_en) begin
                cmd_valid = f_valid; cmd_op = f_op; cmd_mode = f_mode;
            end else begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_op    = 2'($urandom_range(0, 3));
                cmd_mode  = 2'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic check_reset_vals(input string name);
        obs_t g;
        g = dut_obs();
        checks++;
        if (g !== mk(4'b0001, 4'b0001, 0, 0, 1, 8'd0)) begin
            failures++;
            $display("FAIL %s: got mode=%b pos=%b rdy=%b wa=%b busy=%b wc=%0d required mode=0001 pos=0001 rdy=0 wa=0 busy=1 wc=0",
                     name, g.mode, g.pos, g.ready, g.wa, g.busy, g.wc);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        cmd_valid = 0;
        rst_n = 1;
        model_reset();
        exp_q.delete();
        exp_q.push_back(cur);
        mon_en = 1;
    endtask

    task automatic idle_to_cruise();
        for (int i = 0; i < 30 && (plan.size() > 0 || cmd_valid); i++) tick(1, 0, 2'b00, 2'b00);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot(mode_sel)) begin
                failures++;
                $display("FAIL mode_onehot: got %b required one-hot", mode_sel);
            end
            checks++;
            if (!$onehot(pos_sel) || pos_sel == 4'b1000) begin
                failures++;
                $display("FAIL pos_legal: got %b required one of 0001/0010/0100", pos_sel);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_empty: got an output cycle with no expectation queued");
            end else begin
                mon_e = exp_q.pop_front();
                mon_g = dut_obs();
                if (mon_g !== mon_e) begin
                    failures++;
                    $display("FAIL outputs t=%0t: got mode=%b pos=%b rdy=%b wa=%b busy=%b wc=%0d required mode=%b pos=%b rdy=%b wa=%b busy=%b wc=%0d",
                             $time, mon_g.mode, mon_g.pos, mon_g.ready, mon_g.wa, mon_g.busy, mon_g.wc,
                             mon_e.mode, mon_e.pos, mon_e.ready, mon_e.wa, mon_e.busy, mon_e.wc);
                end
            end
        end
    end

    initial begin
        bit found;
        rst_n = 0; cmd_valid = 0; cmd_op = 2'b00; cmd_mode = 2'b00;
        cyc = 0; warps_acc = 0;
        #12;
        check_reset_vals("reset_hold");
        release_reset();

        idle_to_cruise();
        tick(1, 1, 2'b01, 2'd2);
        tick(1, 1, 2'b10, 2'd0);
        for (int i = 0; i < 12; i++) tick(1, 1, 2'b10, 2'd0);

        idle_to_cruise();
        tick(1, 1, 2'b01, 2'd1);
        tick(1, 1, 2'b01, 2'd3);
        for (int i = 0; i < 4; i++) tick(1, 0, 2'b00, 2'd0);
        idle_to_cruise();
        tick(1, 1, 2'b01, 2'd0);
        tick(1, 1, 2'b01, 2'd2);
        tick(1, 1, 2'b01, 2'd2);
        for (int i = 0; i < 3; i++) tick(1, 0, 2'b00, 2'd0);

        for (int i = 0; i < 1500; i++) tick(0, 0, 2'b00, 2'd0);

        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1, 1, 2'b10, 2'd0);
            if (cur.wa) found = 1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL warp_reach: got no warp cycle within 60 cycles required one");
        end
        #2;
        mon_en = 0;
        rst_n = 0;
        #1;
        check_reset_vals("reset_in_warp");
        release_reset();

        warps_acc = 0;
        for (int i = 0; i < 4000 && warps_acc < 265; i++) tick(1, 1, 2'b10, 2'd0);
        checks++;
        if (warps_acc < 265) begin
            failures++;
            $display("FAIL sat_budget: got %0d warps required 265", warps_acc);
        end
        checks++;
        if (warp_count !== 8'd255) begin
            failures++;
            $display("FAIL warp_saturate: got %0d required 255", warp_count);
        end
        for (int i = 0; i < 3; i++) tick(1, 0, 2'b00, 2'd0);
        @(negedge clk);
        #1;
        mon_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
